main_mul_pipe_hs: RTL and testbench

//  Parametrised pipelined integer multiplier with valid/ready handshake, per-transaction

---
 rtl/main_mul_pipe_hs.sv | 211 +++++++++++++++++++++
 tb/tb_main_mul_pipe_hs.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_mul_pipe_hs.sv
// -----------------------------------------------------------------------------
// main_mul_pipe_hs
//   Pipelined integer multiplier with a valid/ready handshake, a signed or
//   unsigned mode chosen per transaction, a tag carried through unchanged, and
//   an occupancy count.
//
//   Stages S0..S(NUM_STAGE-1):
//     S0  input register holding the operands, signed flag and tag
//     S1  product register; the multiply sits between S0 and S1
//     S2+ retiming registers
//   The whole pipe shifts by one on every advance. Bubbles shift like data,
//   and no bubble is ever collapsed. A result therefore appears NUM_STAGE-1
//   advancing edges after it is accepted.
//
//   Optional feature macro: MAIN_MUL_SAT_EN
//     defined   : saturate dout when the product does not fit in DOUT_WIDTH
//                 bits (only when DOUT_WIDTH < DIN0_WIDTH+DIN1_WIDTH).
//     undefined : keep the low DOUT_WIDTH bits of the product (wrap).
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ce                global clock enable; 0 freezes all state
//   in_valid/ready    input handshake; in_ready = advance (combinational)
//   in_signed         1: operands are two's complement, 0: unsigned
//   din0, din1        operands
//   in_tag            sideband tag
//   out_valid/ready   output handshake
//   dout, out_tag     product and tag of the transaction at the output
//   occupancy         number of valid stages in flight
// -----------------------------------------------------------------------------
module main_mul_pipe_hs #(
  parameter int DIN0_WIDTH = 49,
  parameter int DIN1_WIDTH = 49,
  parameter int DOUT_WIDTH = 98,
  parameter int NUM_STAGE  = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ce,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_signed,
  input  logic [DIN0_WIDTH-1:0]              din0,
  input  logic [DIN1_WIDTH-1:0]              din1,
  input  logic [TAG_WIDTH-1:0]               in_tag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DOUT_WIDTH-1:0]              dout,
  output logic [TAG_WIDTH-1:0]               out_tag,
  output logic [$clog2(NUM_STAGE+1)-1:0]     occupancy
);

  localparam int FULL_W = DIN0_WIDTH + DIN1_WIDTH;
  // After both operands are extended by one bit, the exact product
  // needs FULL_W+2 bits.
  localparam int PROD_W = FULL_W + 2;
  localparam int EXT_W  = (DOUT_WIDTH > PROD_W) ? DOUT_WIDTH : PROD_W;
  localparam int OCC_W  = $clog2(NUM_STAGE + 1);

  // S0: input register
  logic                  s0_valid_r;
  logic [DIN0_WIDTH-1:0] s0_a_r;
  logic [DIN1_WIDTH-1:0] s0_b_r;
  logic                  s0_signed_r;
  logic [TAG_WIDTH-1:0]  s0_tag_r;

  // S1..S(NUM_STAGE-1): result stages
  logic                  valid_r [1:NUM_STAGE-1];
  logic [DOUT_WIDTH-1:0] data_r  [1:NUM_STAGE-1];
  logic [TAG_WIDTH-1:0]  tag_r   [1:NUM_STAGE-1];

  logic [OCC_W-1:0]      occupancy_r;
  logic [OCC_W-1:0]      occ_next_s;

  logic                  advance_s;
  logic                  a_fill_s;
  logic                  b_fill_s;
  logic signed [PROD_W-1:0] a_wide_s;
  logic signed [PROD_W-1:0] b_wide_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [EXT_W-1:0]  prod_ext_s;
  logic [DOUT_WIDTH-1:0]    s1_data_s;

  // The pipe moves when enabled and the output slot is empty or being taken.
  assign advance_s = ce & (~valid_r[NUM_STAGE-1] | out_ready);
  assign in_ready  = advance_s;

  // Extend each operand to the product width: use sign extension in signed
  // mode and zero extension otherwise. The signed multiply is then exact.
  assign a_fill_s   = s0_signed_r & s0_a_r[DIN0_WIDTH-1];
  assign b_fill_s   = s0_signed_r & s0_b_r[DIN1_WIDTH-1];
  assign a_wide_s   = {{(PROD_W-DIN0_WIDTH){a_fill_s}}, s0_a_r};
  assign b_wide_s   = {{(PROD_W-DIN1_WIDTH){b_fill_s}}, s0_b_r};
  assign prod_s     = a_wide_s * b_wide_s;
  // Sign extension also zero-extends unsigned products, which are never negative.
  assign prod_ext_s = EXT_W'(prod_s);

`ifdef MAIN_MUL_SAT_EN
  localparam bit SAT_APPLIES = (DOUT_WIDTH < FULL_W);
  localparam logic [DOUT_WIDTH-1:0] SMAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] SMIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic [DOUT_WIDTH-1:0] UMAX = {DOUT_WIDTH{1'b1}};

  // Clamp an exact product to the range of a DOUT_WIDTH-bit result.
  function automatic logic [DOUT_WIDTH-1:0] sat_result(
    input logic signed [EXT_W-1:0] p,
    input logic                    is_signed
  );
    logic signed [EXT_W-1:0] hi;
    logic [DOUT_WIDTH-1:0]   r;
    if (is_signed) begin
      // The product fits when all bits from DOUT_WIDTH-1 upward are equal.
      hi = p >>> (DOUT_WIDTH - 1);
      if ((hi == '0) || (hi == '1)) begin
        r = p[DOUT_WIDTH-1:0];
      end else if (p[EXT_W-1]) begin
        r = SMIN;
      end else begin
        r = SMAX;
      end
    end else begin
      hi = p >>> DOUT_WIDTH;
      if (hi == '0) begin
        r = p[DOUT_WIDTH-1:0];
      end else begin
        r = UMAX;
      end
    end
    return r;
  endfunction

  // Saturate or wrap the product before it enters S1.
  always_comb begin
    s1_data_s = prod_ext_s[DOUT_WIDTH-1:0];
    if (SAT_APPLIES) begin
      s1_data_s = sat_result(prod_ext_s, s0_signed_r);
    end else begin
      s1_data_s = prod_ext_s[DOUT_WIDTH-1:0];
    end
  end
`else
  logic unused_prod_hi_s;
  assign unused_prod_hi_s = ^prod_ext_s;

  // Wrap: keep the low DOUT_WIDTH bits of the product.
  always_comb begin
    s1_data_s = prod_ext_s[DOUT_WIDTH-1:0];
  end
`endif

  // Compute the valid-bit count that results from the next shift.
  always_comb begin
    occ_next_s = OCC_W'(in_valid) + OCC_W'(s0_valid_r);
    for (int i = 1; i < NUM_STAGE - 1; i++) begin
      occ_next_s = occ_next_s + OCC_W'(valid_r[i]);
    end
  end

  // S0 input register: loads on every advance, including bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_r  <= 1'b0;
      s0_a_r      <= '0;
      s0_b_r      <= '0;
      s0_signed_r <= 1'b0;
      s0_tag_r    <= '0;
    end else if (advance_s) begin
      s0_valid_r  <= in_valid;
      s0_a_r      <= din0;
      s0_b_r      <= din1;
      s0_signed_r <= in_signed;
      s0_tag_r    <= in_tag;
    end
  end

  // S1 takes the product; later stages shift the result towards the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_STAGE; i++) begin
        valid_r[i] <= 1'b0;
        data_r[i]  <= '0;
        tag_r[i]   <= '0;
      end
    end else if (advance_s) begin
      valid_r[1] <= s0_valid_r;
      data_r[1]  <= s1_data_s;
      tag_r[1]   <= s0_tag_r;
      for (int i = 2; i < NUM_STAGE; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
        tag_r[i]   <= tag_r[i-1];
      end
    end
  end

  // The occupancy register updates on the same edge as the shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy_r <= '0;
    end else if (advance_s) begin
      occupancy_r <= occ_next_s;
    end
  end

  assign out_valid = valid_r[NUM_STAGE-1];
  assign dout      = data_r[NUM_STAGE-1];
  assign out_tag   = tag_r[NUM_STAGE-1];
  assign occupancy = occupancy_r;

endmodule

// File: tb/tb_main_mul_pipe_hs.sv
module tb_main_mul_pipe_hs;

  localparam int NS = 4;

  logic         clk;
  logic         reset;
  logic         ce;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [48:0]  din0;
  logic [48:0]  din1;
  logic [7:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [97:0]  dout;
  logic [7:0]   out_tag;
  logic [2:0]   occupancy;

  // Narrow instance for the DOUT_WIDTH=8 wrap/saturation cases
  logic         s_in_valid;
  logic         s_in_ready;
  logic         s_in_signed;
  logic [7:0]   s_din0;
  logic [7:0]   s_din1;
  logic [7:0]   s_in_tag;
  logic         s_out_valid;
  logic         s_out_ready;
  logic         s_ce;
  logic [7:0]   s_dout;
  logic [7:0]   s_out_tag;
  logic [1:0]   s_occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [97:0] res;
    logic [7:0]  tag;
    int          age;
  } txn_t;

  txn_t q[$];
  logic last_rst = 1'b0;

  main_mul_pipe_hs #(.DIN0_WIDTH(49), .DIN1_WIDTH(49), .DOUT_WIDTH(98),
                     .NUM_STAGE(NS), .TAG_WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .din0(din0), .din1(din1), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  main_mul_pipe_hs #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8),
                     .NUM_STAGE(3), .TAG_WIDTH(8)) u_small (
    .clk(clk), .reset(reset), .ce(s_ce), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_signed(s_in_signed), .din0(s_din0), .din1(s_din1), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .dout(s_dout), .out_tag(s_out_tag),
    .occupancy(s_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Exact product of the operands read as signed or unsigned, low 98 bits
  function automatic logic [97:0] ref_mul(input logic s, input logic [48:0] a, input logic [48:0] b);
    logic signed [127:0] x;
    logic signed [127:0] y;
    logic signed [127:0] p;
    x = s ? {{79{a[48]}}, a} : {79'd0, a};
    y = s ? {{79{b[48]}}, b} : {79'd0, b};
    p = x * y;
    return p[97:0];
  endfunction

  // Expected 8-bit result of the narrow instance
  function automatic logic [7:0] ref_small(input logic s, input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    int p;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    p = x * y;
`ifdef MAIN_MUL_SAT_EN
    if (s) begin
      if (p > 127) return 8'h7F;
      if (p < -128) return 8'h80;
    end else begin
      if (p > 255) return 8'hFF;
    end
`endif
    return p[7:0];
  endfunction

  function automatic logic [48:0] rand49();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: return {49{1'b1}};
      1: return 49'd0;
      2: return {1'b1, 48'd0};
      3: return {1'b0, {48{1'b1}}};
      default: return t[48:0];
    endcase
  endfunction

  // One clock cycle: drive inputs, check the outputs against the model, then
  // apply the spec rules to the model on the edge.
  task automatic step(input logic rst, input logic ce_v, input logic iv, input logic sg,
                      input logic [48:0] a, input logic [48:0] b, input logic [7:0] tg,
                      input logic ordy);
    logic exp_ov;
    logic adv;
    @(negedge clk);
    reset = rst; ce = ce_v; in_valid = iv; in_signed = sg;
    din0 = a; din1 = b; in_tag = tg; out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (q[0].age == NS - 1);
    adv    = ce_v && (!exp_ov || ordy);
    check_val("out_valid", 128'(out_valid), 128'(exp_ov));
    check_val("in_ready", 128'(in_ready), 128'(adv));
    check_val("occupancy", 128'(occupancy), 128'(q.size()));
    if (exp_ov) begin
      check_val("dout", 128'(dout), 128'(q[0].res));
      check_val("out_tag", 128'(out_tag), 128'(q[0].tag));
    end
    if (last_rst) begin
      check_val("dout_after_reset", 128'(dout), 128'd0);
      check_val("tag_after_reset", 128'(out_tag), 128'd0);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else if (adv) begin
      if (exp_ov) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (iv) q.push_back('{ref_mul(sg, a, b), tg, 0});
    end
    last_rst = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 49'd0, 49'd0, 8'h00, 1'b1);
  endtask

  // One transaction through the narrow instance; checks latency and value.
  task automatic small_run(input logic sg, input logic [7:0] a, input logic [7:0] b, input logic [7:0] tg);
    int n;
    @(negedge clk);
    s_in_valid = 1'b1; s_in_signed = sg; s_din0 = a; s_din1 = b; s_in_tag = tg;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_val("small_latency", 128'(n), 128'd2);
    check_val("small_dout", 128'(s_dout), 128'(ref_small(sg, a, b)));
    check_val("small_tag", 128'(s_out_tag), 128'(tg));
  endtask

  initial begin
    logic [48:0] m2;
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
    din0 = '0; din1 = '0; in_tag = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_signed = 1'b0; s_din0 = '0; s_din1 = '0;
    s_in_tag = '0; s_out_ready = 1'b1; s_ce = 1'b1;

    step(1'b1, 1'b1, 1'b0, 1'b0, 49'd0, 49'd0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 49'd0, 49'd0, 8'h00, 1'b1);

    // Single unsigned 3*5
    step(1'b0, 1'b1, 1'b1, 1'b0, 49'd3, 49'd5, 8'h11, 1'b1);
    idle(5);

    // -2 * 7, first signed and then unsigned, using the same bits
    m2 = {{48{1'b1}}, 1'b0};
    step(1'b0, 1'b1, 1'b1, 1'b1, m2, 49'd7, 8'h12, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, m2, 49'd7, 8'h13, 1'b1);
    idle(5);

    // 10 back-to-back transactions
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'b1, i[0], rand49(), rand49(), 8'(8'h20 + i), 1'b1);
    idle(5);

    // Stream with out_ready low for 5 cycles in the middle
    for (int i = 0; i < 18; i++)
      step(1'b0, 1'b1, (i < 12), i[1], rand49(), rand49(), 8'(8'h40 + i), !(i >= 6 && i < 11));
    idle(5);

    // Stream with ce low for 3 cycles in the middle
    for (int i = 0; i < 14; i++)
      step(1'b0, !(i >= 5 && i < 8), (i < 10), i[0], rand49(), rand49(), 8'(8'h60 + i), 1'b1);
    idle(5);

    // Reset with 3 in flight: those results must never appear
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, rand49(), rand49(), 8'(8'h80 + i), 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 49'd0, 49'd0, 8'h00, 1'b1);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 7), 1'($urandom), rand49(), rand49(),
           8'($urandom), ($urandom_range(0, 9) < 7));
    idle(6);

    // Narrow instance: wrap or saturate
    small_run(1'b0, 8'd20, 8'd20, 8'hA1);
    small_run(1'b1, 8'hEC, 8'd20, 8'hA2);
    small_run(1'b1, 8'hF6, 8'd5, 8'hA3);
    small_run(1'b0, 8'd15, 8'd17, 8'hA4);
    for (int i = 0; i < 6; i++)
      small_run(1'($urandom), 8'($urandom), 8'($urandom), 8'(8'hB0 + i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
